// File: rtl/timer_bank.sv
// timer_bank: multi-channel DIV/TIMA/TMA/TAC timer sharing one M-cycle prescaler,
// with falling-edge tap detection and a one-tick delayed TMA reload per channel.
module timer_bank #(
    parameter int NUM_TIMERS = 1,
    parameter int CNT_W      = 8,
    parameter int PRESCALE_W = 14,
    parameter int ADDR_W     = 5
) (
    input  logic                  iClock,
    input  logic                  iReset,
    input  logic                  iTick,
    input  logic                  iMcuWe,
    input  logic [ADDR_W-1:0]     iMcuRegSelect,
    input  logic [CNT_W-1:0]      iMcuWriteData,
    output logic [CNT_W-1:0]      oReadData,
    output logic [7:0]            oDiv,
    output logic [NUM_TIMERS-1:0] oInterrupt
);
    typedef enum logic [1:0] {RUN, OVF_PEND, RELOAD} state_t;
    logic [PRESCALE_W-1:0] presc_q, presc_d;
    logic [CNT_W-1:0]      tima_q [NUM_TIMERS];
    logic [CNT_W-1:0]      tima_d [NUM_TIMERS];
    logic [CNT_W-1:0]      tma_q  [NUM_TIMERS];
    logic [CNT_W-1:0]      tma_d  [NUM_TIMERS];
    logic [2:0]            tac_q  [NUM_TIMERS];
    logic [2:0]            tac_d  [NUM_TIMERS];
    state_t                st_q   [NUM_TIMERS];
    state_t                st_d   [NUM_TIMERS];
    logic [NUM_TIMERS-1:0] e_q, e_d, irq_q, irq_d, tima_we, tma_we, tac_we;
    logic [3:0]            taps;
    logic                  div_we;
    assign div_we = iMcuWe && iMcuRegSelect == '0;
    // Tap selected by TAC[1:0]: 00->bit7, 01->bit1, 10->bit3, 11->bit5
    assign taps = {presc_q[5], presc_q[3], presc_q[1], presc_q[7]};
    assign oDiv = presc_q[PRESCALE_W-1 -: 8];
    assign oInterrupt = irq_q;
    genvar i;
    generate
        for (i = 0; i < NUM_TIMERS; i++) begin : g_dec
            assign tima_we[i] = iMcuWe && iMcuRegSelect == ADDR_W'(3*i+1);
            assign tma_we[i]  = iMcuWe && iMcuRegSelect == ADDR_W'(3*i+2);
            assign tac_we[i]  = iMcuWe && iMcuRegSelect == ADDR_W'(3*i+3);
        end
    endgenerate
    always_comb begin
        presc_d = div_we ? '0 : presc_q + PRESCALE_W'(iTick);
        for (int n = 0; n < NUM_TIMERS; n++) begin
            e_d[n]    = tac_q[n][2] & taps[tac_q[n][1:0]];
            tima_d[n] = tima_q[n];
            tma_d[n]  = tma_we[n] ? iMcuWriteData : tma_q[n];
            tac_d[n]  = tac_we[n] ? iMcuWriteData[2:0] : tac_q[n];
            st_d[n]   = st_q[n];
            irq_d[n]  = 1'b0;
            case (st_q[n])
                RUN: begin
                    if (tima_we[n]) tima_d[n] = iMcuWriteData;
                    else if (e_q[n] & ~e_d[n]) begin
                        tima_d[n] = tima_q[n] + 1'b1;
                        st_d[n]   = &tima_q[n] ? OVF_PEND : RUN;
                    end
                end
                OVF_PEND: begin
                    if (tima_we[n]) begin
                        tima_d[n] = iMcuWriteData;
                        st_d[n]   = RUN;
                    end else if (iTick) begin
                        tima_d[n] = tma_q[n];
                        irq_d[n]  = 1'b1;
                        st_d[n]   = RELOAD;
                    end
                end
                RELOAD: begin
                    if (tma_we[n]) tima_d[n] = iMcuWriteData;
                    if (iTick) st_d[n] = RUN;
                end
                default: st_d[n] = RUN;
            endcase
        end
    end
    always_ff @(posedge iClock or posedge iReset) begin
        if (iReset) begin
            presc_q <= '0;
            e_q     <= '0;
            irq_q   <= '0;
            for (int n = 0; n < NUM_TIMERS; n++) begin
                tima_q[n] <= '0;
                tma_q[n]  <= '0;
                tac_q[n]  <= '0;
                st_q[n]   <= RUN;
            end
        end else begin
            presc_q <= presc_d;
            e_q     <= e_d;
            irq_q   <= irq_d;
            for (int n = 0; n < NUM_TIMERS; n++) begin
                tima_q[n] <= tima_d[n];
                tma_q[n]  <= tma_d[n];
                tac_q[n]  <= tac_d[n];
                st_q[n]   <= st_d[n];
            end
        end
    end
    always_comb begin
        oReadData = iMcuRegSelect == '0 ? CNT_W'(oDiv) : '0;
        for (int n = 0; n < NUM_TIMERS; n++) begin
            if (iMcuRegSelect == ADDR_W'(3*n+1)) oReadData = tima_q[n];
            if (iMcuRegSelect == ADDR_W'(3*n+2)) oReadData = tma_q[n];
            if (iMcuRegSelect == ADDR_W'(3*n+3)) oReadData = CNT_W'(tac_q[n]);
        end
    end
endmodule

// File: tb/tb_timer_bank.sv
// tb_timer_bank: randomized and directed stimulus for a 3-channel, 12-bit timer_bank,
// expectations from a register-level reference model, checked by a queue-fed monitor.
module tb_timer_bank;
    localparam int NT = 3;
    localparam int CW = 12;
    localparam int MAXV = (1 << CW) - 1;

    logic          iClock = 1'b0;
    logic          iReset = 1'b1;
    logic          iTick = 1'b0;
    logic          iMcuWe = 1'b0;
    logic [4:0]    iMcuRegSelect = '0;
    logic [CW-1:0] iMcuWriteData = '0;
    logic [CW-1:0] oReadData;
    logic [7:0]    oDiv;
    logic [NT-1:0] oInterrupt;

    timer_bank #(.NUM_TIMERS(NT), .CNT_W(CW), .PRESCALE_W(14), .ADDR_W(5)) dut (
        .iClock(iClock), .iReset(iReset), .iTick(iTick), .iMcuWe(iMcuWe),
        .iMcuRegSelect(iMcuRegSelect), .iMcuWriteData(iMcuWriteData),
        .oReadData(oReadData), .oDiv(oDiv), .oInterrupt(oInterrupt)
    );

    always #5 iClock = ~iClock;

    typedef struct packed {
        logic [NT-1:0] irq;
        logic [7:0]    div;
        logic [CW-1:0] rd;
    } exp_t;
    exp_t q[$];
    int n_vec = 0;
    int n_err = 0;

    // Reference model: prescaler count, per-channel registers and phase (0 run, 1 pending, 2 reload)
    int m_presc;
    int m_tima[NT], m_tma[NT], m_tac[NT], m_ph[NT];
    bit m_eprev[NT], m_irq[NT];
    int tapbit[4] = '{7, 1, 3, 5};

    function automatic void m_reset();
        m_presc = 0;
        for (int n = 0; n < NT; n++) begin
            m_tima[n] = 0; m_tma[n] = 0; m_tac[n] = 0; m_ph[n] = 0;
            m_eprev[n] = 0; m_irq[n] = 0;
        end
    endfunction

    function automatic int m_read(int s);
        if (s == 0) return (m_presc >> 6) & 255;
        for (int n = 0; n < NT; n++) begin
            if (s == 3*n+1) return m_tima[n];
            if (s == 3*n+2) return m_tma[n];
            if (s == 3*n+3) return m_tac[n];
        end
        return 0;
    endfunction

    function automatic void m_step(bit w, int s, int d, bit t);
        for (int n = 0; n < NT; n++) begin
            bit e = m_tac[n][2] && ((m_presc >> tapbit[m_tac[n] & 3]) & 1) == 1;
            bit fall = m_eprev[n] && !e;
            bit tw = w && s == 3*n+1;
            bit mw = w && s == 3*n+2;
            bit cw = w && s == 3*n+3;
            m_eprev[n] = e;
            m_irq[n] = 0;
            if (m_ph[n] == 0) begin
                if (tw) m_tima[n] = d;
                else if (fall) begin
                    if (m_tima[n] == MAXV) begin m_tima[n] = 0; m_ph[n] = 1; end
                    else m_tima[n] = m_tima[n] + 1;
                end
            end else if (m_ph[n] == 1) begin
                if (tw) begin m_tima[n] = d; m_ph[n] = 0; end
                else if (t) begin m_tima[n] = m_tma[n]; m_irq[n] = 1; m_ph[n] = 2; end
            end else begin
                if (mw) m_tima[n] = d;
                if (t) m_ph[n] = 0;
            end
            if (mw) m_tma[n] = d;
            if (cw) m_tac[n] = d & 7;
        end
        m_presc = (w && s == 0) ? 0 : (m_presc + int'(t)) % 16384;
    endfunction

    task automatic cyc(input bit w, input int s, input int d, input bit t, input bit r);
        exp_t e;
        @(posedge iClock);
        #2;
        iReset = r; iTick = t; iMcuWe = w;
        iMcuRegSelect = s[4:0]; iMcuWriteData = d[CW-1:0];
        if (r) m_reset();
        e.rd = m_read(s);
        e.div = 8'((m_presc >> 6) & 255);
        for (int n = 0; n < NT; n++) e.irq[n] = m_irq[n];
        q.push_back(e);
        if (!r) m_step(w, s, d, t);
    endtask

    task automatic idle(input int cycles, input int s, input bit t);
        for (int k = 0; k < cycles; k++) cyc(0, s, 0, t, 0);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge iClock);
            if (q.size() > 0) begin
                e = q.pop_front();
                n_vec++;
                if (oReadData !== e.rd) begin
                    n_err++;
                    $display("FAIL rd sel=%0d got=%h exp=%h t=%0t", iMcuRegSelect, oReadData, e.rd, $time);
                end
                if (oDiv !== e.div) begin
                    n_err++;
                    $display("FAIL div got=%h exp=%h t=%0t", oDiv, e.div, $time);
                end
                if (oInterrupt !== e.irq) begin
                    n_err++;
                    $display("FAIL irq got=%b exp=%b t=%0t", oInterrupt, e.irq, $time);
                end
            end
        end
    end

    initial begin
        m_reset();
        cyc(0, 0, 0, 0, 1);
        for (int s = 0; s < 11; s++) cyc(0, s, 0, 0, 0);
        // reset mid-count
        cyc(1, 1, 'h55, 0, 0);
        cyc(1, 3, 5, 0, 0);
        idle(10, 1, 1);
        cyc(0, 1, 0, 1, 1);
        for (int s = 0; s < 4; s++) cyc(0, s, 0, 1, 0);
        idle(20, 1, 1);
        // counting rates
        cyc(1, 3, 5, 1, 0);
        idle(40, 1, 1);
        cyc(1, 3, 4, 1, 0);
        idle(600, 1, 1);
        idle(130, 0, 1);
        // overflow and reload
        cyc(1, 2, 'hFF0, 1, 0);
        cyc(1, 1, 'hFFF, 1, 0);
        cyc(1, 3, 5, 1, 0);
        idle(20, 1, 1);
        // reload cancelled by a TIMA write while pending
        cyc(1, 1, 'hFFF, 1, 0);
        for (int k = 0; k < 50 && m_ph[0] != 1; k++) cyc(0, 1, 0, 1, 0);
        if (m_ph[0] != 1) begin
            n_err++;
            $display("FAIL ovf_wait no overflow within budget");
        end
        cyc(1, 1, 'h10, 1, 0);
        idle(6, 1, 1);
        // DIV write with tap high, then with tap low
        cyc(1, 1, 'h100, 0, 0);
        cyc(1, 0, 0, 0, 0);
        idle(2, 1, 1);
        cyc(1, 0, 0, 0, 0);
        idle(4, 1, 0);
        cyc(1, 0, 0, 0, 0);
        idle(4, 1, 0);
        // simultaneous overflow on channels 0 and 2, channel 1 idle
        cyc(1, 0, 0, 0, 0);
        cyc(1, 6, 0, 0, 0);
        cyc(1, 5, 'h123, 0, 0);
        cyc(1, 1, 'hFFF, 0, 0);
        cyc(1, 7, 'hFFF, 0, 0);
        cyc(1, 3, 5, 0, 0);
        cyc(1, 9, 5, 0, 0);
        idle(12, 4, 1);
        idle(4, 7, 1);
        // randomized traffic biased towards near-overflow counts and fast taps
        for (int k = 0; k < 4000; k++) begin
            int s = $urandom_range(0, 15);
            bit w = $urandom_range(0, 7) == 0;
            int d = $urandom_range(0, MAXV);
            if ((s % 3) == 1 && $urandom_range(0, 1) == 1) d = MAXV - $urandom_range(0, 3);
            if ((s % 3) == 0 && s != 0 && $urandom_range(0, 3) != 0) d = 4 + $urandom_range(0, 3);
            if (s == 0 && $urandom_range(0, 3) != 0) w = 0;
            cyc(w, s, d, $urandom_range(0, 3) != 0, $urandom_range(0, 499) == 0);
        end
        idle(3, 0, 0);
        @(negedge iClock);
        @(negedge iClock);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
